// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The FSM state type, the default width and the counter-width helper live here.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int SUB_W = 7;

    // Keeps the counter at least one bit wide for degenerate widths.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int SUB_CNT_W = cnt_width(SUB_W);

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out of this bit.
// The serial top reuses this single cell for every bit position.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub7.sv
// Bit-serial subtractor: a - b - bi over WIDTH clocks, LSB first, with a start/done handshake.
// diff/bo are registered and only update on the edge that finishes an operation.
module serial_sub7
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bi,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, b_sr_reg, res_sr_reg;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             br_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bo_reg;

    logic load, step, last;
    logic cell_d, cell_bout;

    full_sub_cell u_cell (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .bin  (br_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result bits arrive LSB first, so they enter at the top and walk down.
    assign res_next = {cell_d, res_sr_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                    last       = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            diff_reg   <= '0;
            bo_reg     <= 1'b0;
        end else if (load) begin
            a_sr_reg   <= a_in;
            b_sr_reg   <= b_in;
            res_sr_reg <= '0;
            cnt_reg    <= '0;
            br_reg     <= bi;
        end else if (step) begin
            a_sr_reg   <= a_sr_reg >> 1;
            b_sr_reg   <= b_sr_reg >> 1;
            res_sr_reg <= res_next;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            br_reg     <= cell_bout;
            if (last) begin
                diff_reg <= res_next;
                bo_reg   <= cell_bout;
            end
        end
    end

    assign diff = diff_reg;
    assign bo   = bo_reg;
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_sub7.sv
// Bench for serial_sub7: directed vector table, protocol/reset sequences and a
// random sweep against an integer-arithmetic model of a - b - bi.
module tb_serial_sub7;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         bi;
    logic [W-1:0] diff;
    logic         bo, busy, done;

    always #5 clk = ~clk;

    serial_sub7 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .bi    (bi),
        .diff  (diff),
        .bo    (bo),
        .busy  (busy),
        .done  (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int a;
        int b;
        int bin;
        int d;
        int bout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: a - b - bi as plain integers; low W bits are diff, sign gives the borrow.
    function automatic int model_diff(input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        return r & ((1 << W) - 1);
    endfunction

    function automatic int model_bo(input int a, input int b, input int bin);
        return (a - b - bin < 0) ? 1 : 0;
    endfunction

    // One full operation, observed at negedges from the accepting edge onward.
    task automatic run_op(input int a, input int b, input int bin, input bit scramble,
                          output int got_d, output int got_bo, output int lat,
                          output int busy_cnt, output int done_cnt, output int hold_ok);
        int old_d, old_bo;
        got_d = -1; got_bo = -1; lat = -1; busy_cnt = 0; done_cnt = 0; hold_ok = 1;
        @(negedge clk);
        old_d = int'(diff); old_bo = int'(bo);
        a_in = W'(a); b_in = W'(b); bi = bin[0]; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = i; got_d = int'(diff); got_bo = int'(bo);
                end
            end else if (busy && (int'(diff) != old_d || int'(bo) != old_bo)) begin
                hold_ok = 0;
            end
            if (!busy) break;
            if (scramble) begin
                a_in = W'($urandom); b_in = W'($urandom); bi = 1'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic verify_op(input string name, input int a, input int b, input int bin,
                             input int exp_d, input int exp_bo, input bit scramble);
        int d, o, lat, bc, dc, hk;
        run_op(a, b, bin, scramble, d, o, lat, bc, dc, hk);
        $display("%s: a=%0d b=%0d bi=%0d -> diff=%0d bo=%0d (exp %0d/%0d) lat=%0d busy=%0d",
                 name, a, b, bin, d, o, exp_d, exp_bo, lat, bc);
        check({name, "_diff"}, d, exp_d);
        check({name, "_bo"}, o, exp_bo);
        check({name, "_latency"}, lat, W);
        check({name, "_busy_cycles"}, bc, W + 1);
        check({name, "_done_pulses"}, dc, 1);
        check({name, "_hold_during_shift"}, hk, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("drain_idle", int'(busy), 0);
    endtask

    initial begin
        int first, second, pulses, ra, rb, rbi;

        vecs[0] = '{a: 5,   b: 2,   bin: 0, d: 3,   bout: 0};
        vecs[1] = '{a: 0,   b: 1,   bin: 0, d: 127, bout: 1};
        vecs[2] = '{a: 0,   b: 127, bin: 1, d: 0,   bout: 1};
        vecs[3] = '{a: 85,  b: 1,   bin: 1, d: 83,  bout: 0};
        vecs[4] = '{a: 127, b: 127, bin: 1, d: 127, bout: 1};
        vecs[5] = '{a: 42,  b: 127, bin: 1, d: 42,  bout: 1};
        vecs[6] = '{a: 127, b: 0,   bin: 0, d: 127, bout: 0};
        vecs[7] = '{a: 0,   b: 0,   bin: 1, d: 127, bout: 1};

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; bi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_diff", int'(diff), 0);
        check("reset_bo", int'(bo), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            verify_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                      vecs[i].d, vecs[i].bout, 1'b0);

        // Operands scrambled every cycle after acceptance must not matter.
        verify_op("scramble", 100, 58, 1, 41, 0, 1'b1);

        // start held high: accepts at edges 0, 9, 18; done after edges 7 and 16.
        @(negedge clk);
        a_in = 7'd100; b_in = 7'd37; bi = 1'b1; start = 1'b1;
        first = -1; second = -1; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
                check("held_diff", int'(diff), 62);
            end
        end
        start = 1'b0;
        $display("held_start: pulses=%0d first=%0d second=%0d", pulses, first, second);
        check("held_pulses", pulses, 2);
        check("held_first", first, W);
        check("held_gap", second - first, W + 2);
        drain();

        // start during DONE is dropped.
        @(negedge clk);
        a_in = 7'd9; b_in = 7'd4; bi = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        check("done_seen", int'(done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_diff", int'(diff), 5);
        for (int i = 0; i < 3; i++) begin
            check("start_in_done_ignored", int'(busy), 0);
            @(negedge clk);
        end
        $display("start_in_done: diff=%0d busy=%0d", diff, busy);

        // Asynchronous reset at cycle 3 of an operation.
        verify_op("pre_reset", 100, 1, 0, 99, 0, 1'b0);
        @(negedge clk);
        a_in = 7'd50; b_in = 7'd20; bi = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_diff", int'(diff), 0);
        check("midreset_bo", int'(bo), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        $display("mid_reset: activity_after_release=%0d", pulses);
        check("midreset_no_done", pulses, 0);
        verify_op("post_reset", 50, 20, 0, 30, 0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            ra = int'($urandom_range(0, (1 << W) - 1));
            rb = int'($urandom_range(0, (1 << W) - 1));
            rbi = int'($urandom_range(0, 1));
            verify_op($sformatf("rand%0d", n), ra, rb, rbi,
                      model_diff(ra, rb, rbi), model_bo(ra, rb, rbi), n[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sub7.md
# serial_sub7

Bit-serial subtractor computing `A − B − Bi` over several clock cycles with a start/done handshake. It is the inverse-direction companion to the team's 7-bit ripple adders (A + B + Ci, sum plus carry-out). It sits beside them in the arithmetic lab set and is checked against a behavioural `a − b − bi` model in its own bench. Each operation takes one bit per clock, LSB first, through a single full-subtractor cell.

## Interface
- `WIDTH`, default 7: operand and result width.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a_in` input WIDTH: minuend; captured on the accepting edge.
- `b_in` input WIDTH: subtrahend; captured on the accepting edge.
- `bi` input 1: borrow-in; captured on the accepting edge.
- `diff` output WIDTH: result `(a − b − bi) mod 2^WIDTH`.
- `bo` output 1: borrow-out, 1 when `a < b + bi` (unsigned).
- `busy` output 1: high while state ≠ IDLE.
- `done` output 1: one-cycle pulse when `diff`/`bo` become valid.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE → SHIFT:** on an edge with `start=1`.
  - Load shift registers `a_sr←a_in`, `b_sr←b_in`.
  - Load `br←bi`, `cnt←0`, `res_sr←0`.
- **SHIFT:** each edge processes bit `a_sr[0]`, `b_sr[0]`, `br`:
  - `d = a^b^br`; `br' = (~a & b) | (~(a^b) & br)`.
  - `res_sr` shifts right with `d` entering the MSB.
  - `a_sr` and `b_sr` shift right; `cnt` increments.
- **SHIFT → DONE:** on the edge that processes bit WIDTH−1 (`cnt==WIDTH−1`). On that same edge, `diff←` the final shifted result and `bo←br'`.
- **DONE → IDLE:** unconditionally on the next edge.
- **Output holding:** `diff` and `bo` hold their value from the last completed operation until the next completion. They do not change during SHIFT.
- **`start` handling:**
  - `start` is ignored in SHIFT and DONE; no queuing.
  - A `start` held high continuously begins a new operation on the first edge in IDLE.
- **Operand stability:** changes on `a_in`, `b_in` and `bi` after the accepting edge have no effect.
- **Arithmetic:** unsigned modulo 2^WIDTH. `bo` is the borrow out of bit WIDTH−1.

## Timing
- **Reset values:** `rst=1` forces state IDLE immediately (asynchronous), and all of the following go to 0: `diff`, `bo`, `busy`, `done`, `cnt`, shift registers, `br`.
- **Reset mid-operation:** the operation is aborted and no `done` pulse is produced. After `rst` drops, the block is in IDLE and accepts `start` on the first edge.
- **Edge numbering:** edge 0 is the edge that accepts `start`.
- **Data edges:** edges 1..WIDTH process bits 0..WIDTH−1.
- **Result timing:** `done=1` and valid `diff`/`bo` appear after edge WIDTH (7 by default).
- **Return to IDLE:** `done` drops after edge WIDTH+1, and the state is IDLE.
- **Throughput:** earliest next accept is edge WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- **`busy`:** high from after edge 0 through the DONE cycle, inclusive.
- **`done`:** exactly one cycle per operation and never asserted in IDLE.

## Structure
- **Package `sub_pkg`:**
  - FSM state typedef `sub_state_t` {IDLE, SHIFT, DONE}.
  - Default width constant `SUB_W = 7`.
  - Counter width `$clog2(SUB_W)`.
- **Sub-module `full_sub_cell`:**
  - Combinational: `a`, `b`, `bin` → `d`, `bout`.
  - Instantiated once, mirroring the adders' full-adder cell.
- **Top-level content:** FSM, counter, shift registers and output registers only.

## Test plan
- **Basic subtraction:** `a=5, b=2, bi=0`, `start` pulse → `done` after 7 cycles, `diff=3, bo=0`, `busy` high 8 cycles.
- **Wrap with borrow:** `a=0, b=1, bi=0` → `diff=127, bo=1`. Then `a=0, b=127, bi=1` → `diff=0, bo=1`.
- **Borrow-in effect:**
  - `a=85 (1010101), b=1, bi=1` → `diff=83, bo=0`.
  - `a=127, b=127, bi=1` → `diff=127, bo=1`.
  - `a=42, b=127, bi=1` → `diff=42, bo=1`.
- **Protocol:**
  - `start` held high for 20 cycles → two completions, `done` pulses exactly WIDTH+2 cycles apart.
  - `a_in` changed during SHIFT → result unchanged.
  - `start` pulsed during DONE → ignored.
- **Reset:** `rst` asserted at cycle 3 of an operation → all outputs 0 immediately, no `done` pulse. A fresh `start` after release → correct result with normal latency.
- **Sweep:** random 200 operand/`bi` triples vs behavioural `{bo,diff} = {1'b0,a} − b − bi`, compared on every `done`.
